// File: rtl/snake_text_pkg.sv
// Screen encodings, character codes and the constant per-(screen, line) text tables
// shared by the overlay and its font ROM.
package snake_text_pkg;

    localparam int TBL_CHARS = 16;

    typedef enum logic [1:0] {
        SCR_NONE  = 2'd0,
        SCR_WIN   = 2'd1,
        SCR_LOSE  = 2'd2,
        SCR_START = 2'd3
    } screen_e;

    localparam logic [6:0] CH_E = 7'h45;
    localparam logic [6:0] CH_G = 7'h47;
    localparam logic [6:0] CH_I = 7'h49;
    localparam logic [6:0] CH_L = 7'h4C;
    localparam logic [6:0] CH_N = 7'h4E;
    localparam logic [6:0] CH_O = 7'h4F;
    localparam logic [6:0] CH_S = 7'h53;
    localparam logic [6:0] CH_W = 7'h57;

    typedef struct packed {
        logic [11:0] ox;
        logic [11:0] oy;
        logic [1:0]  s;
        logic [15:0] color;
        logic        blink;
    } line_cfg_t;

    function automatic line_cfg_t line_cfg(input logic [1:0] scr, input int ln);
        line_cfg_t c;
        c = '0;
        case (scr)
            SCR_WIN: case (ln)
                0: c = '{12'd28,  12'd8,   2'd3, 16'h07E0, 1'b0};
                1: c = '{12'd150, 12'd110, 2'd1, 16'hF800, 1'b0};
                2: c = '{12'd300, 12'd200, 2'd0, 16'hFFE0, 1'b0};
                default: ;
            endcase
            SCR_LOSE: case (ln)
                0: c = '{12'd40,  12'd30,  2'd2, 16'hF800, 1'b0};
                1: c = '{12'd40,  12'd30,  2'd2, 16'h001F, 1'b0};
                2: c = '{12'd0,   12'd100, 2'd0, 16'hF81F, 1'b0};
                default: ;
            endcase
            SCR_START: case (ln)
                0: c = '{12'd60,  12'd40,  2'd2, 16'hFFFF, 1'b1};
                1: c = '{12'd100, 12'd120, 2'd1, 16'h07FF, 1'b0};
                default: ;
            endcase
            default: ;
        endcase
        return c;
    endfunction

    // Strings are left-justified ASCII, slot 0 in the top byte; unused slots are 0 (blank).
    function automatic logic [TBL_CHARS*8-1:0] line_text(input logic [1:0] scr, input int ln);
        logic [TBL_CHARS*8-1:0] t;
        t = '0;
        case (scr)
            SCR_WIN: case (ln)
                0, 1:    t = {"WIN", 104'h0};
                2:       t = {"GO", 112'h0};
                default: ;
            endcase
            SCR_LOSE: case (ln)
                0, 1:    t = {"LOSE", 96'h0};
                2:       t = "LOSELOSELOSELOSE";
                default: ;
            endcase
            SCR_START: case (ln)
                0:       t = {"GO", 112'h0};
                1:       t = {"WIN", 104'h0};
                default: ;
            endcase
            default: ;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] line_char(input logic [1:0] scr, input int ln,
                                             input logic [12:0] slot);
        logic [TBL_CHARS*8-1:0] t;
        logic [6:0]             c;
        t = line_text(scr, ln);
        c = '0;
        for (int k = 0; k < TBL_CHARS; k++) begin
            if (slot == 13'(k)) c = 7'(t[8*(TBL_CHARS-1-k) +: 8]);
        end
        return c;
    endfunction

endpackage

// File: rtl/snake_font_rom.sv
// 8x16 glyph ROM: one row byte per (char code, row), bit 7 = leftmost column.
// Latency: 1 clk (registered row byte).
// Backpressure: none; accepts a lookup every clock.
module snake_font_rom
    import snake_text_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] char_code,
    input  logic [3:0] row,
    output logic [7:0] row_byte
);

    logic [127:0] glyph;

    // Row 0 is the most significant byte; codes without a glyph (incl. 0) are blank.
    always_comb begin
        case (char_code)
            CH_W:    glyph = 128'h0000_C6D6_D6D6_D6D6_FEEE_C6C6_0000_0000;
            CH_I:    glyph = 128'h7E18_1818_1818_1818_1818_187E_0000_0000;
            CH_N:    glyph = 128'h0000_C6E6_F6DE_CEC6_C6C6_C6C6_0000_0000;
            CH_L:    glyph = 128'h0000_C0C0_C0C0_C0C0_C0C0_C0FE_0000_0000;
            CH_O:    glyph = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
            CH_S:    glyph = 128'h0000_7CC6_C060_380C_06C6_C67C_0000_0000;
            CH_E:    glyph = 128'h0000_FEC0_C0C0_FCC0_C0C0_C0FE_0000_0000;
            CH_G:    glyph = 128'h0000_7CC6_C0C0_DEC6_C6C6_C67E_0000_0000;
            default: glyph = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) row_byte <= '0;
        else       row_byte <= glyph[{~row, 3'b000} +: 8];
    end

endmodule

// File: rtl/snake_text_overlay.sv
// Text overlay for the snake game screens (win/lose/start) with per-line scale and blink.
// Latency: 2 clk from pixel coordinate to pixel_text/text_hit.
// Backpressure: none; one pixel in and one pixel out every clock.
module snake_text_overlay
    import snake_text_pkg::*;
#(
    parameter int NUM_LINES    = 3,
    parameter int MAX_CHARS    = 16,
    parameter int BLINK_FRAMES = 30,
    parameter int COLOR_W      = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [10:0]        pixel_xpos,
    input  logic [10:0]        pixel_ypos,
    input  logic               frame_start,
    input  logic [1:0]         screen_sel,
    output logic [COLOR_W-1:0] pixel_text,
    output logic               text_hit
);

    localparam int          CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [12:0] BOX_W = 13'(8 * MAX_CHARS);

    logic [1:0]       act_scr;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_ph;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_scr   <= SCR_NONE;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
        end else if (frame_start) begin
            act_scr <= screen_sel;
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    line_cfg_t   cfg;
    logic [12:0] cx, cy, dx;
    logic        hit_d;
    logic [15:0] color_d;
    logic [2:0]  col_d;
    logic [6:0]  rom_char;
    logic [3:0]  rom_row;

    // Walk lines from highest index down so the lowest-index hitting line wins.
    always_comb begin
        cfg      = '0;
        cx       = '0;
        cy       = '0;
        dx       = '0;
        hit_d    = 1'b0;
        color_d  = '0;
        col_d    = '0;
        rom_char = '0;
        rom_row  = '0;
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            cfg = line_cfg(act_scr, l);
            cx  = {2'b00, pixel_xpos} >> cfg.s;
            cy  = {2'b00, pixel_ypos} >> cfg.s;
            dx  = cx - {1'b0, cfg.ox};
            if (act_scr != SCR_NONE && (!cfg.blink || blink_ph)
                && cx >= {1'b0, cfg.ox} && cx < {1'b0, cfg.ox} + BOX_W
                && cy >= {1'b0, cfg.oy} && cy < {1'b0, cfg.oy} + 13'd16) begin
                hit_d    = 1'b1;
                color_d  = cfg.color;
                col_d    = 3'(dx);
                rom_char = line_char(act_scr, l, dx >> 3);
                rom_row  = 4'(cy - {1'b0, cfg.oy});
            end
        end
    end

    logic               s1_hit;
    logic [COLOR_W-1:0] s1_color;
    logic [2:0]         s1_col;
    logic [7:0]         rom_byte;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_hit   <= 1'b0;
            s1_color <= '0;
            s1_col   <= '0;
        end else begin
            s1_hit   <= hit_d;
            s1_color <= COLOR_W'(color_d);
            s1_col   <= col_d;
        end
    end

    snake_font_rom u_font (
        .clk       (clk),
        .rstn      (rstn),
        .char_code (rom_char),
        .row       (rom_row),
        .row_byte  (rom_byte)
    );

    logic glyph_bit;
    assign glyph_bit = rom_byte[~s1_col];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pixel_text <= '0;
            text_hit   <= 1'b0;
        end else begin
            text_hit   <= s1_hit & glyph_bit;
            pixel_text <= (s1_hit && glyph_bit) ? s1_color : '0;
        end
    end

endmodule

// File: tb/tb_snake_text_overlay.sv
// Self-checking bench for snake_text_overlay: directed vectors, multi-cycle corner
// sequences and a randomized pixel stream against a behavioural model.
module tb_snake_text_overlay;
    import snake_text_pkg::*;

    localparam int NL = 3;
    localparam int MC = 16;
    localparam int BF = 2;
    localparam int NRAND = 160;

    logic        clk;
    logic        rstn;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        frame_start;
    logic [1:0]  screen_sel;
    logic [15:0] pixel_text;
    logic        text_hit;

    int errors = 0;
    int checks = 0;
    int nframes = 0;
    int cur_scr = 0;

    typedef struct {
        string       nm;
        int          scr;
        int          x;
        int          y;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs [13];
    logic [16:0] exp_q [NRAND];

    snake_text_overlay #(
        .NUM_LINES    (NL),
        .MAX_CHARS    (MC),
        .BLINK_FRAMES (BF),
        .COLOR_W      (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start),
        .screen_sel  (screen_sel),
        .pixel_text  (pixel_text),
        .text_hit    (text_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    function automatic logic [7:0] font_row(input logic [7:0] ch, input int row);
        logic [127:0] g;
        case (ch)
            "W":     g = 128'h0000_C6D6_D6D6_D6D6_FEEE_C6C6_0000_0000;
            "I":     g = 128'h7E18_1818_1818_1818_1818_187E_0000_0000;
            "N":     g = 128'h0000_C6E6_F6DE_CEC6_C6C6_C6C6_0000_0000;
            "L":     g = 128'h0000_C0C0_C0C0_C0C0_C0C0_C0FE_0000_0000;
            "O":     g = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
            "S":     g = 128'h0000_7CC6_C060_380C_06C6_C67C_0000_0000;
            "E":     g = 128'h0000_FEC0_C0C0_FCC0_C0C0_C0FE_0000_0000;
            "G":     g = 128'h0000_7CC6_C0C0_DEC6_C6C6_C67E_0000_0000;
            default: g = '0;
        endcase
        return g[8*(15-row) +: 8];
    endfunction

    // Blink phase as a function of frame_start pulses seen since reset.
    function automatic bit phase_of(input int n);
        return ((n / BF) % 2) == 0;
    endfunction

    function automatic logic [16:0] model(input int scr, input int x, input int y, input bit ph);
        line_cfg_t    c;
        logic [127:0] t;
        logic [7:0]   rb;
        int cx, cy, ox, oy, slot;
        if (scr == 0) return '0;
        for (int l = 0; l < NL; l++) begin
            c  = line_cfg(2'(scr), l);
            ox = int'(c.ox);
            oy = int'(c.oy);
            cx = x >> c.s;
            cy = y >> c.s;
            if (c.blink && !ph) continue;
            if (cx >= ox && cx < ox + 8*MC && cy >= oy && cy < oy + 16) begin
                t    = line_text(2'(scr), l);
                slot = (cx - ox) / 8;
                rb   = font_row(t[8*(15-slot) +: 8], cy - oy);
                return rb[7 - ((cx - ox) % 8)] ? {1'b1, c.color} : 17'h0;
            end
        end
        return '0;
    endfunction

    task automatic cmp(input string nm, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hit=%0b colour=%h, want hit=%0b colour=%h",
                     nm, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    // Called at a negedge; the result of the driven pixel is visible two edges later.
    task automatic check_px(input string nm, input int x, input int y, input logic [16:0] exp);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        @(negedge clk);
        @(negedge clk);
        cmp(nm, {text_hit, pixel_text}, exp);
    endtask

    task automatic do_frame(input int sel);
        screen_sel  = 2'(sel);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nframes++;
        cur_scr = sel;
    endtask

    initial begin
        vecs[0]  = '{"win_W_row3",      1, 224, 88,  {1'b1, 16'h07E0}};
        vecs[1]  = '{"win_W_col2",      1, 240, 88,  17'h0};
        vecs[2]  = '{"win_I_row0",      1, 304, 64,  {1'b1, 16'h07E0}};
        vecs[3]  = '{"win_row_past_end",1, 304, 192, 17'h0};
        vecs[4]  = '{"win_line2",       1, 300, 203, {1'b1, 16'hFFE0}};
        vecs[5]  = '{"lose_overlap",    2, 160, 140, {1'b1, 16'hF800}};
        vecs[6]  = '{"lose_last_slot",  2, 120, 105, {1'b1, 16'hF81F}};
        vecs[7]  = '{"lose_last_col",   2, 127, 105, 17'h0};
        vecs[8]  = '{"lose_col_past_end",2, 128, 105, 17'h0};
        vecs[9]  = '{"lose_origin",     2, 0,   102, {1'b1, 16'hF81F}};
        vecs[10] = '{"lose_row_past_end",2, 0,  116, 17'h0};
        vecs[11] = '{"start_line1",     3, 200, 246, {1'b1, 16'h07FF}};
        vecs[12] = '{"none_screen",     0, 224, 88,  17'h0};

        rstn        = 1'b0;
        frame_start = 1'b0;
        screen_sel  = 2'd1;
        pixel_xpos  = 11'd224;
        pixel_ypos  = 11'd88;
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cmp("reset_outputs", {text_hit, pixel_text}, 17'h0);
        rstn    = 1'b1;
        nframes = 0;
        cur_scr = 0;
        check_px("bg_after_release", 224, 88, 17'h0);

        for (int f = 1; f <= 6; f++) begin
            do_frame(3);
            check_px($sformatf("blink_frame%0d", nframes), 240, 172,
                     model(3, 240, 172, phase_of(nframes)));
        end

        check_px("pre_reset_hit", 200, 246, {1'b1, 16'h07FF});
        #2;
        rstn = 1'b0;
        #1;
        cmp("async_reset", {text_hit, pixel_text}, 17'h0);
        @(negedge clk);
        rstn    = 1'b1;
        nframes = 0;
        cur_scr = 0;
        do_frame(3);
        check_px("phase_after_reset", 240, 172, {1'b1, 16'hFFFF});

        do_frame(0);
        screen_sel = 2'd1;
        check_px("midframe_sel", 224, 88, 17'h0);
        do_frame(1);
        check_px("sel_next_frame", 224, 88, {1'b1, 16'h07E0});

        for (int i = 0; i < 13; i++) begin
            do_frame(vecs[i].scr);
            check_px(vecs[i].nm, vecs[i].x, vecs[i].y, vecs[i].exp);
        end

        for (int fr = 0; fr < 6; fr++) begin
            do_frame(int'($urandom_range(0, 3)));
            for (int i = 0; i < NRAND; i++) begin
                int x, y;
                if (i >= 2) cmp($sformatf("rand_f%0d_p%0d", fr, i - 2),
                                {text_hit, pixel_text}, exp_q[i-2]);
                x = int'($urandom_range(0, 1299));
                y = int'($urandom_range(0, 299));
                exp_q[i]   = model(cur_scr, x, y, phase_of(nframes));
                pixel_xpos = 11'(x);
                pixel_ypos = 11'(y);
                screen_sel = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            cmp($sformatf("rand_f%0d_p%0d", fr, NRAND - 2), {text_hit, pixel_text}, exp_q[NRAND-2]);
            @(negedge clk);
            cmp($sformatf("rand_f%0d_p%0d", fr, NRAND - 1), {text_hit, pixel_text}, exp_q[NRAND-1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_text_overlay.md
SNAKE_TEXT_OVERLAY -- requirements
Module: snake_text_overlay

Interface
REQ-001 SHALL have parameter NUM_LINES, default 3, number of independent text lines.
REQ-002 SHALL have parameter MAX_CHARS, default 16, character slots per line.
REQ-003 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-004 SHALL have parameter COLOR_W, default 16, pixel colour width.
REQ-005 SHALL have port clk, input, 1, VGA pixel clock.
REQ-006 SHALL have port rstn, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port pixel_xpos, input, 11, current pixel column.
REQ-008 SHALL have port pixel_ypos, input, 11, current pixel row.
REQ-009 SHALL have port frame_start, input, 1, single-cycle pulse once per frame before the first visible pixel.
REQ-010 SHALL have port screen_sel, input, 2, requested screen: 0 none, 1 win, 2 lose, 3 start.
REQ-011 SHALL have port pixel_text, output, COLOR_W, overlay colour.
REQ-012 SHALL have port text_hit, output, 1, high when pixel_text is a glyph foreground pixel.

Function
REQ-013 SHALL produce pixel_text/text_hit for a coordinate exactly 2 clk cycles after it is presented; 1 output per cycle, no stalls.
REQ-014 SHALL give each (screen, line) pair a cell origin (ox, oy), scale shift s in 0..3, colour, blink flag and MAX_CHARS character codes, all constant.
REQ-015 SHALL compute cell coords cx = xpos>>s, cy = ypos>>s; line hit when ox <= cx < ox+8*MAX_CHARS and oy <= cy < oy+16.
REQ-016 SHALL select character slot (cx-ox)>>3, glyph row cy-oy (0 = top), glyph column (cx-ox)&7; column 0 = bit 7 of the row byte.
REQ-017 SHALL treat glyphs as 8x16, one byte per row; character code 0 is blank (never a hit).
REQ-018 SHALL, when several lines hit one pixel, use the lowest line index.
REQ-019 SHALL output colour of the hitting line and text_hit=1 when glyph bit is 1; otherwise pixel_text=0 and text_hit=0.
REQ-020 SHALL latch screen_sel into an active-screen register only on frame_start; mid-frame changes have no visible effect until the next frame.
REQ-021 SHALL output background everywhere while active screen = 0.
REQ-022 SHALL count frame_start pulses 0..BLINK_FRAMES-1, wrap to 0 and toggle a blink phase on wrap; lines with blink flag set render only when phase = 1.
REQ-023 SHALL perform range compares with at least 12-bit unsigned arithmetic so ox+8*MAX_CHARS cannot wrap.

Reset
REQ-024 SHALL, while rstn=0, drive pixel_text=0, text_hit=0, active screen=0, blink counter=0, blink phase=1, pipeline registers=0.
REQ-025 SHALL, after reset release mid-frame, output background until the first frame_start latches screen_sel.

Structure
REQ-026 SHALL place screen encodings, character codes, per-line origin/scale/colour/blink/string tables in package snake_text_pkg.
REQ-027 SHALL use one sub-module snake_font_rom: inputs char code (7 bits) and row (4 bits), registered 8-bit row byte, 1-cycle latency.
REQ-028 SHALL keep stage 1 = hit detect + ROM address, stage 2 = bit select + colour mux.

Verification
REQ-029 SHALL test: win screen, line0 ox=28 oy=8 s=3 'W' row3 = 0xD6; pixel (224,88) -> text_hit=1 with line0 colour 2 cycles later; (240,88) -> text_hit=0, pixel_text=0.
REQ-030 SHALL test: screen_sel 0->1 at mid-frame -> no hit until after next frame_start; then hits appear.
REQ-031 SHALL test: blink line, BLINK_FRAMES=2 -> visible frames 0-1, hidden 2-3, visible 4-5.
REQ-032 SHALL test: overlapping lines 0 and 1 at same pixel -> line0 colour output.
REQ-033 SHALL test: pixel at cx = ox+8*MAX_CHARS (one past end) and cy = oy+16 -> text_hit=0.
REQ-034 SHALL test: rstn asserted mid-line -> pixel_text=0, text_hit=0 immediately (asynchronous), blink phase=1 after release.
